// File: rtl/scoreboard_ctrl_if.sv
// scoreboard_ctrl_if: bundles the decode-issue, writeback, flush and scoreboard status signals.
// Latency: none, wires only.
// Backpressure: iss_stall/iss_fire flow back to decode; writeback and flush carry no backpressure.
interface scoreboard_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int INFL_W   = 7
);
    logic                iss_valid;
    logic [ADDR_W-1:0]   iss_rs1;
    logic                iss_rs1_used;
    logic [ADDR_W-1:0]   iss_rs2;
    logic                iss_rs2_used;
    logic [ADDR_W-1:0]   iss_rd;
    logic                iss_rd_we;
    logic                ds_stall;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic                flush;
    logic                iss_stall;
    logic                iss_fire;
    logic [NUM_REGS-1:0] busy_mask;
    logic [INFL_W-1:0]   inflight;
    logic                underflow_err;

    // Decode/writeback side: drives the uop and retirement, observes the stall/status.
    modport master (
        output iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
        output iss_rd, iss_rd_we, ds_stall, wb_valid, wb_rd, flush,
        input  iss_stall, iss_fire, busy_mask, inflight, underflow_err
    );

    // Scoreboard side.
    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
        input  iss_rd, iss_rd_we, ds_stall, wb_valid, wb_rd, flush,
        output iss_stall, iss_fire, busy_mask, inflight, underflow_err
    );
endinterface

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: per-register pending-write counters that hold decode on source hazards and counter saturation.
// Latency: issue decision is combinational; a retired write frees its register next cycle (same cycle when SCOREBOARD_WB_BYPASS_EN is defined).
// Backpressure: iss_stall holds decode on hazard, ds_stall or flush; writeback is never back-pressured.
module scoreboard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int INFL_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    scoreboard_ctrl_if.slave sb
);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [INFL_W-1:0] INFL_ONE = INFL_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [INFL_W-1:0]   inflight_q, inflight_d;
    logic                underflow_q, underflow_d;

    logic [CNT_W-1:0]    rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
    logic                rs1_byp, rs2_byp;
    logic                haz1, haz2, hazw;
    logic                fire, inc, dec, unf;
    logic [NUM_REGS-1:0] busy;

    // Hazard evaluation and issue decision from current counters and the uop in decode.
    always_comb begin
        rs1_cnt = cnt_q[sb.iss_rs1];
        rs2_cnt = cnt_q[sb.iss_rs2];
        rd_cnt  = cnt_q[sb.iss_rd];
        wb_cnt  = cnt_q[sb.wb_rd];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Regfile writes through, so the last pending write retiring now satisfies a reader now.
        rs1_byp = sb.wb_valid && (sb.wb_rd == sb.iss_rs1) && (rs1_cnt == CNT_ONE);
        rs2_byp = sb.wb_valid && (sb.wb_rd == sb.iss_rs2) && (rs2_cnt == CNT_ONE);
`else
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
`endif
        haz1 = sb.iss_rs1_used && (sb.iss_rs1 != '0) && (rs1_cnt != '0) && !rs1_byp;
        haz2 = sb.iss_rs2_used && (sb.iss_rs2 != '0) && (rs2_cnt != '0) && !rs2_byp;
        hazw = sb.iss_rd_we && (sb.iss_rd != '0) && (rd_cnt == CNT_MAX);
        // Gated by rst so nothing issues while the counters are held in reset.
        fire = rst && sb.iss_valid && !haz1 && !haz2 && !hazw && !sb.ds_stall && !sb.flush;
        inc  = fire && sb.iss_rd_we && (sb.iss_rd != '0);
        dec  = sb.wb_valid && (sb.wb_rd != '0) && (wb_cnt != '0);
        unf  = sb.wb_valid && (sb.wb_rd != '0) && (wb_cnt == '0) && !sb.flush;
    end

    // Next-state counters: flush wipes everything; otherwise apply issue increment and retire decrement.
    always_comb begin
        cnt_d       = cnt_q;
        inflight_d  = inflight_q;
        underflow_d = underflow_q;
        if (sb.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_d[r] = '0;
            end
            inflight_d = '0;
        end else begin
            if (inc) begin
                cnt_d[sb.iss_rd] = cnt_q[sb.iss_rd] + CNT_ONE;
            end
            // Reads cnt_d so an increment and decrement on the same register cancel.
            if (dec) begin
                cnt_d[sb.wb_rd] = cnt_d[sb.wb_rd] - CNT_ONE;
            end
            if (inc && !dec) begin
                inflight_d = inflight_q + INFL_ONE;
            end else if (dec && !inc) begin
                inflight_d = inflight_q - INFL_ONE;
            end
            if (unf) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers; reset clears all tracking immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            inflight_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    // Busy mask decoded from registered counters only; register 0 is never incremented so its bit stays 0.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign sb.iss_fire      = fire;
    assign sb.iss_stall     = sb.iss_valid && !fire;
    assign sb.busy_mask     = busy;
    assign sb.inflight      = inflight_q;
    assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: directed scenarios plus random traffic against a count-per-register model.
// Latency: model advances on each rising edge, compared on each falling edge.
// Backpressure: ds_stall and flush are driven randomly alongside hazards.
module tb_scoreboard_ctrl;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int IW   = 7;
    localparam int CMAX = (1 << CW) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scoreboard_ctrl_if #(.NUM_REGS(NR), .ADDR_W(AW), .INFL_W(IW)) sbif();

    scoreboard_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW), .INFL_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    int checks   = 0;
    int failures = 0;
    int m_cnt [NR];
    bit m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit src_ok(input bit used, input int a);
        if (!used || a == 0 || m_cnt[a] == 0) return 1'b1;
        if (BYP && sbif.wb_valid && int'(sbif.wb_rd) == a && m_cnt[a] == 1) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: compare on falling edge, then advance state as the coming rising edge will.
    always @(negedge clk) begin
        bit             e_fire;
        logic [NR-1:0]  e_busy;
        int             e_inf;
        int             rd, wr;
        if (!rst) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_err = 1'b0;
            chk("m_rst_fire", sbif.iss_fire, 0);
            chk("m_rst_stall", sbif.iss_stall, sbif.iss_valid);
            chk("m_rst_busy", sbif.busy_mask, 0);
            chk("m_rst_infl", sbif.inflight, 0);
            chk("m_rst_err", sbif.underflow_err, 0);
        end else begin
            rd = int'(sbif.iss_rd);
            wr = int'(sbif.wb_rd);
            e_fire = sbif.iss_valid
                     && src_ok(sbif.iss_rs1_used, int'(sbif.iss_rs1))
                     && src_ok(sbif.iss_rs2_used, int'(sbif.iss_rs2))
                     && !(sbif.iss_rd_we && rd != 0 && m_cnt[rd] == CMAX)
                     && !sbif.ds_stall && !sbif.flush;
            e_busy = '0;
            e_inf  = 0;
            for (int r = 0; r < NR; r++) begin
                e_busy[r] = (m_cnt[r] != 0);
                e_inf += m_cnt[r];
            end
            chk("m_fire", sbif.iss_fire, e_fire);
            chk("m_stall", sbif.iss_stall, sbif.iss_valid && !e_fire);
            chk("m_busy", sbif.busy_mask, e_busy);
            chk("m_infl", sbif.inflight, e_inf);
            chk("m_err", sbif.underflow_err, m_err);
            if (sbif.flush) begin
                for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            end else begin
                if (sbif.wb_valid && wr != 0) begin
                    if (m_cnt[wr] > 0) m_cnt[wr]--;
                    else m_err = 1'b1;
                end
                if (e_fire && sbif.iss_rd_we && rd != 0) m_cnt[rd]++;
            end
        end
    end

    task automatic idle();
        sbif.iss_valid    = 1'b0;
        sbif.iss_rs1      = '0;
        sbif.iss_rs1_used = 1'b0;
        sbif.iss_rs2      = '0;
        sbif.iss_rs2_used = 1'b0;
        sbif.iss_rd       = '0;
        sbif.iss_rd_we    = 1'b0;
        sbif.ds_stall     = 1'b0;
        sbif.wb_valid     = 1'b0;
        sbif.wb_rd        = '0;
        sbif.flush        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int r);
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = AW'(r);
        sbif.iss_rd_we = 1'b1;
    endtask

    initial begin
        int r0;
        int k;
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_fire", sbif.iss_fire, 0);
        chk("rst_busy", sbif.busy_mask, 0);
        chk("rst_infl", sbif.inflight, 0);
        chk("rst_err", sbif.underflow_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // RAW hazard on r5 released by writeback
        issue_wr(5);
        #1 chk("s1_issue_fire", sbif.iss_fire, 1);
        step();
        idle();
        sbif.iss_valid = 1'b1; sbif.iss_rs1 = 5; sbif.iss_rs1_used = 1'b1;
        #1;
        chk("s1_stall", sbif.iss_stall, 1);
        chk("s1_busy5", sbif.busy_mask[5], 1);
        chk("s1_infl", sbif.inflight, 1);
        step();
        chk("s1_stall2", sbif.iss_stall, 1);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 5;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("s1_wb_cycle_fire", sbif.iss_fire, 1);
`else
        chk("s1_wb_cycle_fire", sbif.iss_fire, 0);
`endif
        step();
        sbif.wb_valid = 1'b0;
        #1;
        chk("s1_next_fire", sbif.iss_fire, 1);
        chk("s1_busy5_clr", sbif.busy_mask[5], 0);
        chk("s1_infl_clr", sbif.inflight, 0);
        step();
        idle();

        // Saturation on r7
        issue_wr(7);
        step(); step(); step();
        #1;
        chk("s2_sat_stall", sbif.iss_stall, 1);
        chk("s2_sat_fire", sbif.iss_fire, 0);
        chk("s2_infl3", sbif.inflight, 3);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 7;
        #1 chk("s2_sat_wb_stall", sbif.iss_stall, 1);
        step();
        sbif.wb_valid = 1'b0;
        #1;
        chk("s2_fourth_fire", sbif.iss_fire, 1);
        chk("s2_infl2", sbif.inflight, 2);
        step();
        idle();
        #1;
        chk("s2_infl_back3", sbif.inflight, 3);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 7;
        repeat (3) step();
        idle();
        #1;
        chk("s2_drained", sbif.inflight, 0);
        chk("s2_busy_clr", sbif.busy_mask, 0);

        // Same-register issue and retire cancel
        issue_wr(3);
        step();
        sbif.wb_valid = 1'b1; sbif.wb_rd = 3;
        #1 chk("s3_fire", sbif.iss_fire, 1);
        step();
        idle();
        #1;
        chk("s3_infl", sbif.inflight, 1);
        chk("s3_busy3", sbif.busy_mask[3], 1);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 3;
        step();
        idle();
        #1;
        chk("s3_infl_clr", sbif.inflight, 0);
        chk("s3_busy3_clr", sbif.busy_mask[3], 0);

        // Flush with concurrent issue and writeback
        issue_wr(2); step();
        issue_wr(4); step();
        issue_wr(6); step();
        idle();
        #1;
        chk("s5_infl3", sbif.inflight, 3);
        chk("s5_busy", sbif.busy_mask, 32'h0000_0054);
        sbif.flush = 1'b1;
        issue_wr(8);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 2;
        #1;
        chk("s5_flush_fire", sbif.iss_fire, 0);
        chk("s5_flush_stall", sbif.iss_stall, 1);
        step();
        idle();
        #1;
        chk("s5_busy_clr", sbif.busy_mask, 0);
        chk("s5_infl_clr", sbif.inflight, 0);
        chk("s5_no_err", sbif.underflow_err, 0);

        // Underflow behaviour
        sbif.wb_valid = 1'b1; sbif.wb_rd = 0;
        step();
        idle();
        #1 chk("s4_r0_no_err", sbif.underflow_err, 0);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 9;
        step();
        idle();
        #1;
        chk("s4_err_set", sbif.underflow_err, 1);
        chk("s4_infl", sbif.inflight, 0);
        chk("s4_busy", sbif.busy_mask, 0);
        step(); step();
        chk("s4_err_sticky", sbif.underflow_err, 1);

        // Register 0 operands, downstream stall, mid-run reset
        sbif.iss_valid = 1'b1;
        sbif.iss_rs1_used = 1'b1; sbif.iss_rs2_used = 1'b1; sbif.iss_rd_we = 1'b1;
        #1 chk("s6_r0_fire", sbif.iss_fire, 1);
        step();
        chk("s6_r0_infl", sbif.inflight, 0);
        chk("s6_r0_busy", sbif.busy_mask, 0);
        sbif.ds_stall = 1'b1;
        #1;
        chk("s6_ds_fire", sbif.iss_fire, 0);
        chk("s6_ds_stall", sbif.iss_stall, 1);
        idle();
        issue_wr(10);
        step();
        idle();
        #1 chk("s6_pre_rst_infl", sbif.inflight, 1);
        #1 rst = 1'b0;
        #1;
        chk("s6_rst_busy", sbif.busy_mask, 0);
        chk("s6_rst_infl", sbif.inflight, 0);
        chk("s6_rst_err", sbif.underflow_err, 0);
        chk("s6_rst_fire", sbif.iss_fire, 0);
        step();
        rst = 1'b1;
        issue_wr(11);
        #1 chk("s6_first_fire", sbif.iss_fire, 1);
        step();
        idle();

        // Random traffic on a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            sbif.iss_valid    = ($urandom_range(0, 9) < 7);
            sbif.iss_rs1      = AW'($urandom_range(0, 7));
            sbif.iss_rs1_used = $urandom_range(0, 1);
            sbif.iss_rs2      = AW'($urandom_range(0, 7));
            sbif.iss_rs2_used = $urandom_range(0, 1);
            sbif.iss_rd       = AW'($urandom_range(0, 7));
            sbif.iss_rd_we    = ($urandom_range(0, 3) != 0);
            sbif.ds_stall     = ($urandom_range(0, 9) < 2);
            sbif.flush        = ($urandom_range(0, 49) == 0);
            sbif.wb_valid     = ($urandom_range(0, 9) < 4);
            r0 = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0) begin
                for (k = 0; k < 8; k++) begin
                    if (m_cnt[(r0 + k) % 8] > 0) break;
                end
                if (k < 8) r0 = (r0 + k) % 8;
            end
            sbif.wb_rd = AW'(r0);
            if (c == 1500) rst = 1'b0;
            if (c == 1502) rst = 1'b1;
            step();
        end
        idle();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
